// File: rtl/alu_pkg.sv
// Shared encodings and the decoded-op record used between the decoder and
// the issue pipeline.
package alu_pkg;

    localparam int DATA_W    = 32;
    localparam int ALU_OPC_W = 4;

    localparam logic [ALU_OPC_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OPC_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OPC_W-1:0] ALU_SLL = 4'd2;
    localparam logic [ALU_OPC_W-1:0] ALU_XOR = 4'd3;
    localparam logic [ALU_OPC_W-1:0] ALU_SRL = 4'd4;
    localparam logic [ALU_OPC_W-1:0] ALU_SRA = 4'd5;
    localparam logic [ALU_OPC_W-1:0] ALU_OR  = 4'd6;
    localparam logic [ALU_OPC_W-1:0] ALU_AND = 4'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [ALU_OPC_W-1:0] opcode;
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic [4:0]           rd;
        logic                 we;
        logic                 is_beq;
        logic                 is_bne;
        logic                 illegal;
        logic [DATA_W-1:0]    br_target;
    } dec_op_t;

    function automatic logic [DATA_W-1:0] b_imm(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode into ALU opcode, operands and writeback sideband.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    input  logic [DATA_W-1:0] pc,
    output dec_op_t           op
);

    logic [6:0]           opc;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [4:0]           rd;
    logic [DATA_W-1:0]    imm_i;
    logic                 legal;
    logic                 writes;
    logic                 beq;
    logic                 bne;
    logic [ALU_OPC_W-1:0] aop;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign rd    = instr[11:7];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};

    always_comb begin
        legal  = 1'b1;
        writes = 1'b1;
        beq    = 1'b0;
        bne    = 1'b0;
        aop    = ALU_ADD;
        a      = rs1;
        b      = rs2;
        case (opc)
            OPC_OP: begin
                case (f3)
                    F3_ADD_SUB: begin
                        if (f7 == F7_ALT)       aop = ALU_SUB;
                        else if (f7 != F7_BASE) legal = 1'b0;
                    end
                    F3_SLL: begin
                        aop = ALU_SLL;
                        b   = {27'b0, rs2[4:0]};
                        if (f7 != F7_BASE) legal = 1'b0;
                    end
                    F3_XOR: begin
                        aop = ALU_XOR;
                        if (f7 != F7_BASE) legal = 1'b0;
                    end
                    F3_SR: begin
                        b = {27'b0, rs2[4:0]};
                        if (f7 == F7_ALT)       aop = ALU_SRA;
                        else if (f7 == F7_BASE) aop = ALU_SRL;
                        else                    legal = 1'b0;
                    end
                    F3_OR: begin
                        aop = ALU_OR;
                        if (f7 != F7_BASE) legal = 1'b0;
                    end
                    F3_AND: begin
                        aop = ALU_AND;
                        if (f7 != F7_BASE) legal = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                b = imm_i;
                case (f3)
                    F3_ADD_SUB: aop = ALU_ADD;
                    F3_XOR:     aop = ALU_XOR;
                    F3_OR:      aop = ALU_OR;
                    F3_AND:     aop = ALU_AND;
                    F3_SLL: begin
                        aop = ALU_SLL;
                        b   = {27'b0, instr[24:20]};
                        if (f7 != F7_BASE) legal = 1'b0;
                    end
                    F3_SR: begin
                        b = {27'b0, instr[24:20]};
                        if (f7 == F7_ALT)       aop = ALU_SRA;
                        else if (f7 == F7_BASE) aop = ALU_SRL;
                        else                    legal = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                a = '0;
                b = {instr[31:12], 12'b0};
            end
            OPC_BRANCH: begin
                aop    = ALU_SUB;
                writes = 1'b0;
                if (f3 == F3_BEQ)      beq = 1'b1;
                else if (f3 == F3_BNE) bne = 1'b1;
                else                   legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal ops still flow down the pipe as a harmless ADD 0+0.
    always_comb begin
        op.opcode    = legal ? aop : ALU_ADD;
        op.a         = legal ? a : '0;
        op.b         = legal ? b : '0;
        op.rd        = (legal && writes) ? rd : 5'd0;
        op.we        = legal && writes && (rd != 5'd0);
        op.is_beq    = legal && beq;
        op.is_bne    = legal && bne;
        op.illegal   = !legal;
        op.br_target = pc + b_imm(instr);
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Two-stage ALU requester: E drives the external ALU, W captures its result
// plus writeback/branch sideband for the downstream consumer.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OPC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    output logic [OPC_W-1:0] alu_opcode,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    input  logic [XLEN-1:0]  alu_y,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output logic             out_br_taken,
    output logic [XLEN-1:0]  out_br_target,
    output logic             out_illegal
);

    dec_op_t dec;
    dec_op_t e_q;
    logic    valid_e;
    logic    valid_w;
    logic    adv_e;
    logic    adv_w;
    logic    in_fire;

    alu_issue_decode u_decode (
        .instr (in_instr),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .pc    (in_pc),
        .op    (dec)
    );

    // A transfer happens on an edge where valid and ready are both high; a
    // stage advances when it is empty or the stage after it is advancing.
    assign adv_w    = !valid_w || out_ready;
    assign adv_e    = !valid_e || adv_w;
    assign in_ready = adv_e;
    assign in_fire  = in_valid && adv_e;

    // E keeps its last contents when emptied so the ALU inputs never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e <= 1'b0;
            e_q     <= '0;
        end else if (adv_e) begin
            valid_e <= in_fire;
            if (in_fire) e_q <= dec;
        end
    end

    assign alu_opcode = e_q.opcode;
    assign alu_a      = e_q.a;
    assign alu_b      = e_q.b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_w       <= 1'b0;
            out_result    <= '0;
            out_rd        <= '0;
            out_we        <= 1'b0;
            out_br_taken  <= 1'b0;
            out_br_target <= '0;
            out_illegal   <= 1'b0;
        end else if (adv_w) begin
            valid_w <= valid_e;
            if (valid_e) begin
                out_result    <= alu_y;
                out_rd        <= e_q.rd;
                out_we        <= e_q.we;
                out_br_taken  <= (e_q.is_beq && alu_zero) || (e_q.is_bne && !alu_zero);
                out_br_target <= e_q.br_target;
                out_illegal   <= e_q.illegal;
            end
        end
    end

    assign out_valid = valid_w;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU, vector table, scoreboard queue.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_pc;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_br_taken;
    logic [31:0] out_br_target;
    logic        out_illegal;

    always #5 clk = ~clk;

    // Reference single-cycle ALU
    always_comb begin
        case (alu_opcode)
            4'd0:    alu_y = alu_a + alu_b;
            4'd1:    alu_y = alu_a - alu_b;
            4'd2:    alu_y = alu_a << alu_b[4:0];
            4'd3:    alu_y = alu_a ^ alu_b;
            4'd4:    alu_y = alu_a >> alu_b[4:0];
            4'd5:    alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'd6:    alu_y = alu_a | alu_b;
            4'd7:    alu_y = alu_a & alu_b;
            default: alu_y = 32'hDEAD_BEEF;
        endcase
    end
    assign alu_zero = (alu_y == 32'd0);

    alu_issue_unit #(.XLEN(32), .OPC_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_pc         (in_pc),
        .alu_opcode    (alu_opcode),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_y         (alu_y),
        .alu_zero      (alu_zero),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_we        (out_we),
        .out_br_taken  (out_br_taken),
        .out_br_target (out_br_target),
        .out_illegal   (out_illegal)
    );

    typedef struct {
        logic [31:0] instr, rs1, rs2, pc;
        logic [3:0]  e_opc;
        logic [31:0] e_a, e_b, e_res;
        logic [4:0]  e_rd;
        logic        e_we, e_tk;
        logic [31:0] e_tgt;
        logic        e_ill, chk_tgt;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we, tk;
        logic [31:0] tgt;
        logic        ill, chk;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    vec_t             vecs [16];
    logic [EXP_W-1:0] exp_q [$];
    logic [EXP_W-1:0] cur_exp;
    int               total = 0;
    int               bad   = 0;

    task automatic check(input string name, input logic ok, input string detail);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack_exp(input vec_t v);
        exp_t e;
        e = '{v.e_res, v.e_rd, v.e_we, v.e_tk, v.e_tgt, v.e_ill, v.chk_tgt};
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (in_valid && in_ready) exp_q.push_back(cur_exp);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1'b0,
                              $sformatf("got result=%h rd=%0d with empty queue", out_result, out_rd));
                    end else begin
                        e = exp_q.pop_front();
                        check("out_record",
                              out_result == e.res && out_rd == e.rd && out_we == e.we &&
                              out_br_taken == e.tk && out_illegal == e.ill &&
                              (!e.chk || out_br_target == e.tgt),
                              $sformatf("got res=%h rd=%0d we=%0b tk=%0b tgt=%h ill=%0b need res=%h rd=%0d we=%0b tk=%0b tgt=%h ill=%0b",
                                        out_result, out_rd, out_we, out_br_taken, out_br_target, out_illegal,
                                        e.res, e.rd, e.we, e.tk, e.tgt, e.ill));
                    end
                end
            end
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input int idx);
        int k;
        in_instr = vecs[idx].instr;
        in_rs1   = vecs[idx].rs1;
        in_rs2   = vecs[idx].rs2;
        in_pc    = vecs[idx].pc;
        cur_exp  = pack_exp(vecs[idx]);
        in_valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 50) check("accept_timeout", 1'b0, $sformatf("vector %0d never accepted", idx));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 20; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", exp_q.size() == 0, $sformatf("%0d results still pending", exp_q.size()));
        @(posedge clk);
        #1;
    endtask

    task automatic check_alu(input string name, input int idx);
        check(name,
              alu_opcode == vecs[idx].e_opc && alu_a == vecs[idx].e_a && alu_b == vecs[idx].e_b,
              $sformatf("vec %0d got opc=%0d a=%h b=%h need opc=%0d a=%h b=%h", idx,
                        alu_opcode, alu_a, alu_b, vecs[idx].e_opc, vecs[idx].e_a, vecs[idx].e_b));
    endtask

    initial begin
        //             instr         rs1           rs2           pc            opc   a             b             res           rd    we    tk    tgt           ill   chk
        vecs[0]  = '{32'h002081B3, 32'd5,        32'd7,        32'h0,        4'd0, 32'd5,        32'd7,        32'd12,       5'd3, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{32'h4041D193, 32'h80000000, 32'h0,        32'h0,        4'd5, 32'h80000000, 32'd4,        32'hF8000000, 5'd3, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[2]  = '{32'h123452B7, 32'hAAAA5555, 32'h1,        32'h0,        4'd0, 32'h0,        32'h12345000, 32'h12345000, 5'd5, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[3]  = '{32'h00209863, 32'd9,        32'd9,        32'h100,      4'd1, 32'd9,        32'd9,        32'd0,        5'd0, 1'b0, 1'b0, 32'h110,      1'b0, 1'b1};
        vecs[4]  = '{32'h00208863, 32'd9,        32'd9,        32'h100,      4'd1, 32'd9,        32'd9,        32'd0,        5'd0, 1'b0, 1'b1, 32'h110,      1'b0, 1'b1};
        vecs[5]  = '{32'h0000007F, 32'h55,       32'h66,       32'h40,       4'd0, 32'h0,        32'h0,        32'h0,        5'd0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[6]  = '{32'h40208233, 32'd10,       32'd3,        32'h0,        4'd1, 32'd10,       32'd3,        32'd7,        5'd4, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{32'hFFF08313, 32'd5,        32'h0,        32'h0,        4'd0, 32'd5,        32'hFFFFFFFF, 32'd4,        5'd6, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{32'h002093B3, 32'd3,        32'h21,       32'h0,        4'd2, 32'd3,        32'd1,        32'd6,        5'd7, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[9]  = '{32'h0020A1B3, 32'd1,        32'd2,        32'h0,        4'd0, 32'h0,        32'h0,        32'h0,        5'd0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[10] = '{32'h00208033, 32'd1,        32'd2,        32'h0,        4'd0, 32'd1,        32'd2,        32'd3,        5'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[11] = '{32'h4020C1B3, 32'd1,        32'd2,        32'h0,        4'd0, 32'h0,        32'h0,        32'h0,        5'd0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[12] = '{32'h0020F1B3, 32'h0000F0F0, 32'h0000FF00, 32'h0,        4'd7, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 5'd3, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[13] = '{32'h0020E1B3, 32'h0000F0F0, 32'h0000FF00, 32'h0,        4'd6, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 5'd3, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[14] = '{32'h00208863, 32'd3,        32'd4,        32'hFFFFFFF8, 4'd1, 32'd3,        32'd4,        32'hFFFFFFFF, 5'd0, 1'b0, 1'b0, 32'h8,        1'b0, 1'b1};
        vecs[15] = '{32'h00209863, 32'd3,        32'd4,        32'h200,      4'd1, 32'd3,        32'd4,        32'hFFFFFFFF, 5'd0, 1'b0, 1'b1, 32'h210,      1'b0, 1'b1};

        // Clock / reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        cur_exp   = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              !out_valid && out_result == 0 && out_rd == 0 && !out_we && !out_br_taken &&
              out_br_target == 0 && !out_illegal && alu_opcode == 0 && alu_a == 0 && alu_b == 0,
              $sformatf("got valid=%0b res=%h opc=%0d a=%h b=%h need all zero",
                        out_valid, out_result, alu_opcode, alu_a, alu_b));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready == 1'b1, $sformatf("got in_ready=%0b need 1", in_ready));
        @(posedge clk);
        #1;

        fork
            monitor();
        join_none

        // One instruction at a time: ALU ports in the E cycle, then the W record
        for (int i = 0; i < 16; i++) begin
            send(i);
            @(negedge clk);
            check_alu("alu_ports", i);
            drain();
        end

        // Four back-to-back with a 3-cycle downstream stall mid-stream
        out_ready = 1'b1;
        fork
            begin
                for (int s = 0; s < 4; s++) send(s);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1 out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("stall_ready", in_ready == 1'b0 && out_valid == 1'b1,
                          $sformatf("cycle %0d got in_ready=%0b out_valid=%0b need 0/1", c, in_ready, out_valid));
                    check_alu("stall_alu_hold", 1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages full discards everything in flight
        out_ready = 1'b0;
        send(6);
        send(7);
        #2 rst_n = 1'b0;
        #1;
        check("reset_midflight",
              !out_valid && alu_opcode == 0 && alu_a == 0 && alu_b == 0 && out_result == 0,
              $sformatf("got valid=%0b opc=%0d a=%h b=%h res=%h need all zero",
                        out_valid, alu_opcode, alu_a, alu_b, out_result));
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("quiet_after_reset", !out_valid && in_ready,
              $sformatf("got out_valid=%0b in_ready=%0b need 0/1", out_valid, in_ready));
        @(posedge clk);
        #1;

        // Pipeline still works after the mid-flight reset
        send(12);
        @(negedge clk);
        check_alu("alu_after_reset", 12);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
